cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Parametrised run controller wrapped around the pipeline CPU core. It generates a stretched core reset from the system reset, then counts executed cycles. It ends the run on one of three events: an explicit halt request (ecall/ebreak retire), a hung core (PC frozen), or a cycle budget. It replaces fixed-delay reset and fixed-time run control with a synthesizable block, usable in both simulation and FPGA bring-up.

## Interface
Parameters:
- RST_CYCLES, 4 — core reset hold length in CLK cycles after RESET falls; ≥1.
- CYCLE_W, 32 — width of the cycle counter.
- MAX_CYCLES, 312 — cycle budget; 0 disables timeout; must be < 2^CYCLE_W.
- PC_W, 32 — program counter width.
- STALL_LIMIT, 8 — consecutive unchanged-PC cycles that declare a hang; 0 disables hang detection.

Ports:
- CLK  in  1  — system clock, rising-edge.
- RESET  in  1  — asynchronous, active-high reset.
- PC  in  PC_W  — current fetch PC from the core.
- HALT_REQ  in  1  — core retired ecall/ebreak this cycle.
- CPU_RESET  out  1  — reset to the core, active-high, registered.
- RUNNING  out  1  — high while in RUN.
- DONE  out  1  — sticky; high in any terminal state.
- TIMEOUT  out  1  — sticky; run ended by budget.
- HUNG  out  1  — sticky; run ended by frozen PC.
- CYCLE_COUNT  out  CYCLE_W  — RUN cycles elapsed.
- EXIT_PC  out  PC_W  — PC sampled on the terminating edge.

## Operation
- States: HOLD, RUN, HALTED, TIMED_OUT, HUNG_ST. HALTED, TIMED_OUT and HUNG_ST are terminal and are left only via RESET.
- HOLD: CPU_RESET=1; hold counter counts rising edges. On the RST_CYCLES-th edge after RESET falls, go to RUN and set CPU_RESET=0.
- RUN: CYCLE_COUNT increments by 1 every edge; saturates at all-ones.
- Hang tracking: pc_prev and stall_cnt are updated every RUN edge. A pc_prev_valid flag is cleared on RUN entry, so the first RUN cycle never counts as a stall.
  - PC==pc_prev with valid set: stall_cnt+1.
  - Otherwise: stall_cnt=0.
- Termination, evaluated each RUN edge, priority HALT_REQ > hang > timeout:
  - HALT_REQ=1 → HALTED.
  - STALL_LIMIT≠0 and the stall increment makes stall_cnt==STALL_LIMIT → HUNG_ST, HUNG=1.
  - MAX_CYCLES≠0 and the incremented CYCLE_COUNT==MAX_CYCLES → TIMED_OUT, TIMEOUT=1.
- On every termination edge: EXIT_PC←PC, DONE=1, RUNNING=0, CPU_RESET=1 (core parked in reset), and CYCLE_COUNT freezes.
- HALT_REQ and PC are ignored outside RUN.

## Timing
- Reset values (asynchronous on RESET rise):
  - CPU_RESET=1.
  - RUNNING=0, DONE=0, TIMEOUT=0, HUNG=0.
  - CYCLE_COUNT=0, EXIT_PC=0.
  - State=HOLD, hold counter=0, stall_cnt=0, pc_prev_valid=0.
- CPU_RESET falls on edge RST_CYCLES after RESET deassertion; RUNNING rises on the same edge.
- Termination has one-edge latency: status flags and EXIT_PC change on the edge that samples the event.
- A halt on the same edge as a hang or timeout reports only HALTED; TIMEOUT and HUNG stay 0.
- RESET asserted mid-HOLD, mid-RUN or in a terminal state: immediate return to reset values; a new HOLD sequence starts when RESET falls.
- CYCLE_COUNT at termination equals the number of RUN edges including the terminating edge.
- All outputs are registered; no combinational paths from inputs to outputs.

## Structure
- Package cpu_run_pkg:
  - run_state_t enum (HOLD, RUN, HALTED, TIMED_OUT, HUNG_ST).
  - End-cause localparams for bench decoding.
- Sub-module reset_stretcher (RST_CYCLES parameter) produces the HOLD→RUN release pulse. The FSM, cycle counter and stall tracker stay in cpu_run_ctrl.
- Parameter checks are elaboration-time assertions: RST_CYCLES≥1; MAX_CYCLES fits CYCLE_W.

## Test plan
- Reset release, RST_CYCLES=4: RESET high 4 ns then low → CPU_RESET=1 for exactly 4 edges, then 0 with RUNNING=1; CYCLE_COUNT=0 at release.
- Halt: PC increments by 4 each cycle, HALT_REQ pulsed on RUN cycle 20 → DONE=1, TIMEOUT=0, HUNG=0, CYCLE_COUNT=20, EXIT_PC=PC at that edge, CPU_RESET=1.
- Timeout, MAX_CYCLES=312: PC always changing, no HALT_REQ → TIMEOUT=1, DONE=1 at CYCLE_COUNT=312; outputs frozen for 50 further cycles.
- Hang, STALL_LIMIT=8: PC fixed at 0x40 from RUN cycle 10 → HUNG=1 when stall_cnt reaches 8, EXIT_PC=0x40.
- Collision: HALT_REQ on the same edge the budget expires (MAX_CYCLES=16, halt on cycle 16) → DONE=1, TIMEOUT=0.
- Mid-run reset: RESET pulsed at RUN cycle 30 → all outputs return to reset values asynchronously; a full HOLD of 4 cycles repeats, and CYCLE_COUNT restarts at 0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// +------------------------------------------------------------------+
// | cpu_run_pkg : shared run-controller state and end-cause encodings |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_run_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    RUN       = 3'd1,
    HALTED    = 3'd2,
    TIMED_OUT = 3'd3,
    HUNG_ST   = 3'd4
  } run_state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_HALT    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_HANG    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_reset_stretcher.sv
// +------------------------------------------------------------------+
// | reset_stretcher : counts HOLD edges, flags the RST_CYCLES-th one  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module reset_stretcher #(
  parameter int RST_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic release_run
);

  localparam int CNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RST_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  // Combinational so the owning FSM can leave HOLD on the very edge that completes the count.
  assign release_run = en && (hold_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// +------------------------------------------------------------------+
// | cpu_run_ctrl : core reset stretch, cycle count, halt/hang/timeout |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST_CYCLES  = 4,
  parameter int CYCLE_W     = 32,
  parameter int MAX_CYCLES  = 312,
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [PC_W-1:0]    PC,
  input  logic               HALT_REQ,
  output logic               CPU_RESET,
  output logic               RUNNING,
  output logic               DONE,
  output logic               TIMEOUT,
  output logic               HUNG,
  output logic [CYCLE_W-1:0] CYCLE_COUNT,
  output logic [PC_W-1:0]    EXIT_PC
);

  localparam int STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [CYCLE_W-1:0] BUDGET    = CYCLE_W'(MAX_CYCLES);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  if (RST_CYCLES < 1) begin : g_chk_rst_cycles
    $error("cpu_run_ctrl: RST_CYCLES must be at least 1");
  end
  if (MAX_CYCLES < 0 || (CYCLE_W < 32 && (MAX_CYCLES >> CYCLE_W) != 0)) begin : g_chk_budget
    $error("cpu_run_ctrl: MAX_CYCLES does not fit in CYCLE_W bits");
  end

  run_state_t          state_q, state_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                hung_q, hung_d;
  logic [CYCLE_W-1:0]  cycle_q, cycle_d;
  logic [PC_W-1:0]     exit_pc_q, exit_pc_d;
  logic [PC_W-1:0]     pc_prev_q, pc_prev_d;
  logic                pc_prev_valid_q, pc_prev_valid_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic                release_run;
  logic [CYCLE_W-1:0]  cycle_inc;
  logic                stall_match;
  logic [STALL_W-1:0]  stall_inc;
  logic                hang_hit;
  logic                budget_hit;

  reset_stretcher #(
    .RST_CYCLES (RST_CYCLES)
  ) u_reset_stretcher (
    .clk         (CLK),
    .rst         (RESET),
    .en          (state_q == HOLD),
    .release_run (release_run)
  );

  assign cycle_inc   = (&cycle_q) ? cycle_q : cycle_q + CYCLE_W'(1);
  assign stall_match = pc_prev_valid_q && (PC == pc_prev_q);
  assign stall_inc   = !stall_match ? '0 : ((&stall_q) ? stall_q : stall_q + STALL_W'(1));
  assign hang_hit    = (STALL_LIMIT != 0) && stall_match && (stall_inc == STALL_MAX);
  assign budget_hit  = (MAX_CYCLES != 0) && (cycle_inc == BUDGET);

  always_comb begin
    state_d         = state_q;
    cpu_reset_d     = cpu_reset_q;
    running_d       = running_q;
    done_d          = done_q;
    timeout_d       = timeout_q;
    hung_d          = hung_q;
    cycle_d         = cycle_q;
    exit_pc_d       = exit_pc_q;
    pc_prev_d       = pc_prev_q;
    pc_prev_valid_d = pc_prev_valid_q;
    stall_d         = stall_q;

    case (state_q)
      HOLD: begin
        if (release_run) begin
          state_d         = RUN;
          cpu_reset_d     = 1'b0;
          running_d       = 1'b1;
          pc_prev_valid_d = 1'b0;
          stall_d         = '0;
        end
      end
      RUN: begin
        cycle_d         = cycle_inc;
        pc_prev_d       = PC;
        pc_prev_valid_d = 1'b1;
        stall_d         = stall_inc;
        // Halt outranks hang, which outranks the budget; only the winner raises its flag.
        if (HALT_REQ || hang_hit || budget_hit) begin
          exit_pc_d   = PC;
          done_d      = 1'b1;
          running_d   = 1'b0;
          cpu_reset_d = 1'b1;
          if (HALT_REQ) begin
            state_d = HALTED;
          end else if (hang_hit) begin
            state_d = HUNG_ST;
            hung_d  = 1'b1;
          end else begin
            state_d   = TIMED_OUT;
            timeout_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q         <= HOLD;
      cpu_reset_q     <= 1'b1;
      running_q       <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      hung_q          <= 1'b0;
      cycle_q         <= '0;
      exit_pc_q       <= '0;
      pc_prev_q       <= '0;
      pc_prev_valid_q <= 1'b0;
      stall_q         <= '0;
    end else begin
      state_q         <= state_d;
      cpu_reset_q     <= cpu_reset_d;
      running_q       <= running_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      hung_q          <= hung_d;
      cycle_q         <= cycle_d;
      exit_pc_q       <= exit_pc_d;
      pc_prev_q       <= pc_prev_d;
      pc_prev_valid_q <= pc_prev_valid_d;
      stall_q         <= stall_d;
    end
  end

  assign CPU_RESET   = cpu_reset_q;
  assign RUNNING     = running_q;
  assign DONE        = done_q;
  assign TIMEOUT     = timeout_q;
  assign HUNG        = hung_q;
  assign CYCLE_COUNT = cycle_q;
  assign EXIT_PC     = exit_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// +------------------------------------------------------------------+
// | tb_cpu_run_ctrl : randomized self-checking bench for cpu_run_ctrl |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int RST   = 4;
  localparam int STALL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_a = '0, pc_b = '0;
  logic        halt_a = 1'b0, halt_b = 1'b0;

  logic        a_cpu_reset, a_running, a_done, a_timeout, a_hung;
  logic [31:0] a_count, a_exit;
  logic        b_cpu_reset, b_running, b_done, b_timeout, b_hung;
  logic [31:0] b_count, b_exit;

  always #5 clk = ~clk;

  cpu_run_ctrl dut_a (
    .CLK(clk), .RESET(rst), .PC(pc_a), .HALT_REQ(halt_a),
    .CPU_RESET(a_cpu_reset), .RUNNING(a_running), .DONE(a_done),
    .TIMEOUT(a_timeout), .HUNG(a_hung), .CYCLE_COUNT(a_count), .EXIT_PC(a_exit)
  );

  cpu_run_ctrl #(.MAX_CYCLES(16)) dut_b (
    .CLK(clk), .RESET(rst), .PC(pc_b), .HALT_REQ(halt_b),
    .CPU_RESET(b_cpu_reset), .RUNNING(b_running), .DONE(b_done),
    .TIMEOUT(b_timeout), .HUNG(b_hung), .CYCLE_COUNT(b_count), .EXIT_PC(b_exit)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Run-level reference: counts RUN edges, keeps the last STALL+1 PCs, decides the end cause.
  int          m_n;
  int          m_max;
  logic [31:0] m_hist[$];
  logic [1:0]  m_cause;
  logic [31:0] m_exit;

  task automatic model_reset(input int max_cycles);
    m_n = 0; m_max = max_cycles; m_hist.delete(); m_cause = CAUSE_NONE; m_exit = '0;
  endtask

  task automatic model_step(input logic [31:0] pc, input logic halt);
    bit frozen;
    if (m_cause != CAUSE_NONE) return;
    m_n++;
    m_hist.push_back(pc);
    if (m_hist.size() > STALL + 1) void'(m_hist.pop_front());
    frozen = (m_hist.size() == STALL + 1);
    foreach (m_hist[i]) if (m_hist[i] !== m_hist[0]) frozen = 0;
    if (halt)                          m_cause = CAUSE_HALT;
    else if (frozen)                   m_cause = CAUSE_HANG;
    else if (m_max != 0 && m_n == m_max) m_cause = CAUSE_TIMEOUT;
    if (m_cause != CAUSE_NONE) m_exit = pc;
  endtask

  task automatic drive(input bit sel_b, input logic [31:0] pc, input logic halt);
    if (sel_b) begin pc_b = pc; halt_b = halt; end
    else       begin pc_a = pc; halt_a = halt; end
    @(posedge clk); #1;
    model_step(pc, halt);
    halt_a = 1'b0; halt_b = 1'b0;
  endtask

  task automatic pulse_reset(input int max_cycles);
    @(negedge clk);
    rst = 1'b1; halt_a = 1'b0; halt_b = 1'b0; pc_a = '0; pc_b = '0;
    #4 rst = 1'b0;
    repeat (RST) @(posedge clk);
    #1;
    model_reset(max_cycles);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #4;
    n_checks++;
    if ({a_cpu_reset, a_running, a_done, a_timeout, a_hung} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=10000", {a_cpu_reset, a_running, a_done, a_timeout, a_hung});
    end
    n_checks++;
    if (a_count !== 32'd0 || a_exit !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs count=%0d exit=%h exp=0/0", a_count, a_exit);
    end
    rst = 1'b0;
    for (int e = 1; e <= RST; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_cpu_reset !== (e < RST) || a_running !== (e == RST)) begin
        n_fail++; $display("FAIL release_edge%0d cpu_reset=%b running=%b exp=%b/%b", e, a_cpu_reset, a_running, e < RST, e == RST);
      end
    end
    n_checks++;
    if (a_count !== 32'd0) begin
      n_fail++; $display("FAIL release_count got=%0d exp=0", a_count);
    end
  endtask

  task automatic test_halt();
    logic [31:0] base = $urandom & 32'hFFFF_FF00;
    pulse_reset(312);
    for (int k = 1; k <= 25; k++) begin
      drive(0, base + 32'(4 * k), k == 20);
      n_checks++;
      if (a_done !== (m_cause != CAUSE_NONE) || a_count !== 32'(m_n)) begin
        n_fail++; $display("FAIL halt_cycle%0d done=%b count=%0d exp=%b/%0d", k, a_done, a_count, m_cause != CAUSE_NONE, m_n);
      end
    end
    n_checks++;
    if (a_count !== 32'd20 || a_exit !== base + 32'd80) begin
      n_fail++; $display("FAIL halt_end count=%0d exit=%h exp=20/%h", a_count, a_exit, base + 32'd80);
    end
    n_checks++;
    if ({a_timeout, a_hung, a_running, a_cpu_reset} !== 4'b0001) begin
      n_fail++; $display("FAIL halt_flags got=%b exp=0001", {a_timeout, a_hung, a_running, a_cpu_reset});
    end
  endtask

  task automatic test_timeout();
    logic [31:0] pc = $urandom;
    pulse_reset(312);
    for (int k = 1; k <= 312 + 50; k++) begin
      pc = pc + 32'($urandom_range(1, 100));
      drive(0, pc, 1'b0);
      if (k >= 312) begin
        n_checks++;
        if (a_count !== 32'd312 || a_timeout !== 1'b1 || a_done !== 1'b1 || a_exit !== m_exit) begin
          n_fail++; $display("FAIL timeout_cycle%0d count=%0d to=%b done=%b exit=%h exp=312/1/1/%h", k, a_count, a_timeout, a_done, a_exit, m_exit);
        end
      end
    end
    n_checks++;
    if ({a_hung, a_running, a_cpu_reset} !== 3'b001) begin
      n_fail++; $display("FAIL timeout_flags got=%b exp=001", {a_hung, a_running, a_cpu_reset});
    end
  endtask

  task automatic test_hang();
    pulse_reset(312);
    for (int k = 1; k <= 30; k++) begin
      drive(0, (k < 10) ? (($urandom | 32'h1000) + 32'(k)) : 32'h40, 1'b0);
      n_checks++;
      if (a_hung !== (m_cause == CAUSE_HANG) || a_count !== 32'(m_n)) begin
        n_fail++; $display("FAIL hang_cycle%0d hung=%b count=%0d exp=%b/%0d", k, a_hung, a_count, m_cause == CAUSE_HANG, m_n);
      end
    end
    n_checks++;
    if (a_exit !== 32'h40 || a_count !== 32'd18 || a_timeout !== 1'b0 || a_done !== 1'b1) begin
      n_fail++; $display("FAIL hang_end exit=%h count=%0d to=%b done=%b exp=40/18/0/1", a_exit, a_count, a_timeout, a_done);
    end
  endtask

  task automatic test_collision();
    logic [31:0] pc = $urandom;
    pulse_reset(16);
    for (int k = 1; k <= 20; k++) begin
      pc = pc + 32'd4;
      drive(1, pc, k == 16);
    end
    n_checks++;
    if ({b_done, b_timeout, b_hung} !== 3'b100 || b_count !== 32'd16 || b_exit !== m_exit) begin
      n_fail++; $display("FAIL collision done/to/hung=%b count=%0d exit=%h exp=100/16/%h", {b_done, b_timeout, b_hung}, b_count, b_exit, m_exit);
    end
  endtask

  task automatic test_mid_run_reset();
    logic [31:0] pc = $urandom;
    pulse_reset(312);
    for (int k = 1; k <= 30; k++) begin
      pc = pc + 32'd4;
      drive(0, pc, 1'b0);
    end
    n_checks++;
    if (a_count !== 32'd30 || a_running !== 1'b1) begin
      n_fail++; $display("FAIL midrun_pre count=%0d running=%b exp=30/1", a_count, a_running);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({a_cpu_reset, a_running, a_done, a_timeout, a_hung} !== 5'b10000 || a_count !== 32'd0 || a_exit !== 32'd0) begin
      n_fail++; $display("FAIL midrun_async flags=%b count=%0d exit=%h exp=10000/0/0", {a_cpu_reset, a_running, a_done, a_timeout, a_hung}, a_count, a_exit);
    end
    #2 rst = 1'b0;
    for (int e = 1; e <= RST; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_cpu_reset !== (e < RST) || a_running !== (e == RST) || a_count !== 32'd0) begin
        n_fail++; $display("FAIL midrun_hold%0d cpu_reset=%b running=%b count=%0d exp=%b/%b/0", e, a_cpu_reset, a_running, a_count, e < RST, e == RST);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [31:0] pc = $urandom;
      pulse_reset(312);
      for (int k = 1; k <= 330; k++) begin
        if ($urandom_range(0, 99) >= 60) pc = $urandom;
        drive(0, pc, $urandom_range(0, 149) == 0);
        n_checks++;
        if (a_done !== (m_cause != CAUSE_NONE) || a_running !== (m_cause == CAUSE_NONE) ||
            a_hung !== (m_cause == CAUSE_HANG) || a_timeout !== (m_cause == CAUSE_TIMEOUT) ||
            a_count !== 32'(m_n) || a_exit !== m_exit) begin
          n_fail++;
          $display("FAIL random it%0d cyc%0d done/run/hung/to=%b%b%b%b count=%0d exit=%h exp cause=%0d count=%0d exit=%h",
                   it, k, a_done, a_running, a_hung, a_timeout, a_count, a_exit, m_cause, m_n, m_exit);
        end
        if (m_cause != CAUSE_NONE && m_n + 3 < k) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_timeout();
    test_hang();
    test_collision();
    test_mid_run_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
